// File: rtl/pool1_pkg.sv
// pool1_pkg: constants and FSM encoding shared across the pooling stage.
// Holds the Q1.7 element format, the conv/pool dimensions and the state type.
package pool1_pkg;

  // Q1.7 signed elements: 1 sign bit, 7 fraction bits, LSB = 1/128.
  localparam int DATA_W      = 8;
  localparam int Q_FRAC_BITS = 7;
  localparam logic signed [DATA_W-1:0] Q_MAX  = 8'sh7F;  // +127/128
  localparam logic signed [DATA_W-1:0] Q_MIN  = 8'sh80;  // -1.0
  localparam logic signed [DATA_W-1:0] Q_ZERO = 8'sh00;

  // Network geometry: conv input, conv output (= pool input), pool output.
  localparam int CONV_IN_DIM  = 28;
  localparam int CONV_OUT_DIM = 24;
  localparam int POOL_OUT_DIM = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pool1_max4.sv
// max4_s: combinational signed maximum of four DATA_W elements, with an
// optional clamp of negative results to zero when RELU != 0.
// Ports: a_i..d_i  window elements (signed)
//        y_o       max(a,b,c,d), or max(that,0) with RELU
module max4_s #(
  parameter int DATA_W = 8,
  parameter int RELU   = 0
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [DATA_W-1:0] c_i,
  input  logic signed [DATA_W-1:0] d_i,
  output logic signed [DATA_W-1:0] y_o
);

  logic signed [DATA_W-1:0] m_ab, m_cd, m_all;

  always_comb begin
    m_ab  = (a_i > b_i)   ? a_i  : b_i;
    m_cd  = (c_i > d_i)   ? c_i  : d_i;
    m_all = (m_ab > m_cd) ? m_ab : m_cd;
    // Sign bit set means negative; clamp only when ReLU is enabled.
    y_o   = ((RELU != 0) && m_all[DATA_W-1]) ? '0 : m_all;
  end

endmodule

// File: rtl/pool1.sv
// pool1: 2x2 stride-2 signed max-pool over an IN_DIM x IN_DIM feature map,
// one output element per enabled RUN cycle, row-major.
// Ports: clk        clock (rising edge)
//        iRst_n     async active-low reset
//        ena        start/run enable (producer's done)
//        tensor_in  flattened input map, element (r,c) at (r*IN_DIM+c)*DATA_W
//        ovf_in     producer overflow flag
//        tensor_out flattened pooled map, element (r,c) at (r*IN_DIM/2+c)*DATA_W
//        overflow   sticky ovf_in for the current run
//        done       result complete
module pool1 #(
  parameter int IN_DIM = 24,
  parameter int DATA_W = pool1_pkg::DATA_W,
  parameter int RELU   = 0
) (
  input  logic                                    clk,
  input  logic                                    iRst_n,
  input  logic                                    ena,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]         tensor_in,
  input  logic                                    ovf_in,
  output logic [(IN_DIM/2)*(IN_DIM/2)*DATA_W-1:0] tensor_out,
  output logic                                    overflow,
  output logic                                    done
);
  import pool1_pkg::*;

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int IW      = $clog2(IN_DIM);
  localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);

  state_e                   state_q;
  logic [CW-1:0]            row_q, col_q;
  logic [DATA_W-1:0]        out_q [OUT_DIM][OUT_DIM];
  logic                     overflow_q, done_q;

  logic signed [DATA_W-1:0] in_e  [IN_DIM][IN_DIM];
  logic [IW-1:0]            r0, r1, c0, c1;
  logic signed [DATA_W-1:0] win_a, win_b, win_c, win_d, pooled;

  // 2-D view of the flat input bus.
  for (genvar r = 0; r < IN_DIM; r++) begin : g_in_r
    for (genvar c = 0; c < IN_DIM; c++) begin : g_in_c
      assign in_e[r][c] = tensor_in[(r*IN_DIM+c)*DATA_W +: DATA_W];
    end
  end

  // Window origin is (2*row, 2*col); the odd neighbours just set the LSB.
  always_comb begin
    r0    = IW'({row_q, 1'b0});
    c0    = IW'({col_q, 1'b0});
    r1    = r0 | IW'(1);
    c1    = c0 | IW'(1);
    win_a = in_e[r0][c0];
    win_b = in_e[r0][c1];
    win_c = in_e[r1][c0];
    win_d = in_e[r1][c1];
  end

  max4_s #(.DATA_W(DATA_W), .RELU(RELU)) u_max4 (
    .a_i (win_a),
    .b_i (win_b),
    .c_i (win_c),
    .d_i (win_d),
    .y_o (pooled)
  );

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      out_q      <= '{default: '0};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ena) begin
            state_q    <= RUN;
            row_q      <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
          end
        end
        RUN: begin
          if (ovf_in) overflow_q <= 1'b1;
          // ena low pauses: counters and map hold.
          if (ena) begin
            out_q[row_q][col_q] <= pooled;
            if (col_q == LAST) begin
              col_q <= '0;
              if (row_q == LAST) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (ovf_in) overflow_q <= 1'b1;
          if (!ena) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < OUT_DIM; r++) begin : g_out_r
    for (genvar c = 0; c < OUT_DIM; c++) begin : g_out_c
      assign tensor_out[(r*OUT_DIM+c)*DATA_W +: DATA_W] = out_q[r][c];
    end
  end

  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pool1.sv
// tb_pool1: directed checks of pool1 (RELU=0 instance dut, RELU=1 instance dut_r
// sharing the same inputs). Timing: from ena rising in IDLE, one edge enters
// RUN and 144 more write the elements, so done is seen after edge 145.
module tb_pool1;
  localparam int IN  = 24;
  localparam int OD  = 12;
  localparam int W   = 8;
  localparam int INW = IN*IN*W;
  localparam int OW  = OD*OD*W;

  logic           clk = 1'b0, rst_n = 1'b0, ena = 1'b0, ovf = 1'b0;
  logic [INW-1:0] tin = '0;
  logic [OW-1:0]  tout, tout_r;
  logic           ovf_o, ovf_r, done, done_r;
  int             n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  pool1 #(.IN_DIM(IN), .DATA_W(W), .RELU(0)) dut (
    .clk(clk), .iRst_n(rst_n), .ena(ena), .tensor_in(tin), .ovf_in(ovf),
    .tensor_out(tout), .overflow(ovf_o), .done(done));

  pool1 #(.IN_DIM(IN), .DATA_W(W), .RELU(1)) dut_r (
    .clk(clk), .iRst_n(rst_n), .ena(ena), .tensor_in(tin), .ovf_in(ovf),
    .tensor_out(tout_r), .overflow(ovf_r), .done(done_r));

  // ---------------- stimulus builders and reference ----------------
  function automatic logic [INW-1:0] fill(input logic [W-1:0] v);
    return {(IN*IN){v}};
  endfunction

  function automatic logic [OW-1:0] ofill(input logic [W-1:0] v);
    return {(OD*OD){v}};
  endfunction

  function automatic logic [INW-1:0] ramp();
    logic [INW-1:0] t;
    for (int r = 0; r < IN; r++)
      for (int c = 0; c < IN; c++)
        t[(r*IN+c)*W +: W] = W'((r*IN + c) % 128);
    return t;
  endfunction

  // Every 2x2 window = {0x10, 0x7F / 0x80, 0x00}.
  function automatic logic [INW-1:0] window_pat();
    logic [INW-1:0] t;
    logic [W-1:0]   v;
    for (int r = 0; r < IN; r++)
      for (int c = 0; c < IN; c++) begin
        case ({r[0], c[0]})
          2'b00:   v = 8'h10;
          2'b01:   v = 8'h7F;
          2'b10:   v = 8'h80;
          default: v = 8'h00;
        endcase
        t[(r*IN+c)*W +: W] = v;
      end
    return t;
  endfunction

  function automatic logic [OW-1:0] pool_ref(input logic [INW-1:0] t, input bit relu);
    logic [OW-1:0]   o;
    logic signed [W-1:0] a, b, c, d, m;
    for (int r = 0; r < OD; r++)
      for (int k = 0; k < OD; k++) begin
        a = t[((2*r)*IN + 2*k)*W +: W];
        b = t[((2*r)*IN + 2*k+1)*W +: W];
        c = t[((2*r+1)*IN + 2*k)*W +: W];
        d = t[((2*r+1)*IN + 2*k+1)*W +: W];
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (relu && m < 0) m = '0;
        o[(r*OD+k)*W +: W] = m;
      end
    return o;
  endfunction

  function automatic int first_diff(input logic [OW-1:0] x, input logic [OW-1:0] y);
    for (int i = 0; i < OD*OD; i++)
      if (x[i*W +: W] !== y[i*W +: W]) return i;
    return 0;
  endfunction

  function automatic logic [W-1:0] oel(input logic [OW-1:0] t, input int r, input int c);
    return t[(r*OD+c)*W +: W];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; tin = '0;
    tick(2);
    n_tot++; if (tout !== '0) $display("FAIL reset_map got nonzero exp=0"); else n_pass++;
    n_tot++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_tot++; if (ovf_o !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf_o); else n_pass++;
  endtask

  // Reset released with ena already high: RUN starts on the first edge.
  task automatic test_const();
    logic [OW-1:0] e;
    int i;
    tin = fill(8'h22); ena = 1'b1;
    rst_n = 1'b1;
    e = ofill(8'h22);
    tick(144);
    n_tot++; if (done !== 1'b0) $display("FAIL const_early_done got=%b exp=0", done); else n_pass++;
    tick(1);
    n_tot++; if (done !== 1'b1) $display("FAIL const_done got=%b exp=1", done); else n_pass++;
    n_tot++;
    if (tout !== e) begin
      i = first_diff(tout, e);
      $display("FAIL const_map elem %0d got=%h exp=%h", i, tout[i*W +: W], e[i*W +: W]);
    end else n_pass++;
    n_tot++; if (tout_r !== e) $display("FAIL const_map_relu elem %0d got=%h exp=22", first_diff(tout_r, e), tout_r[first_diff(tout_r, e)*W +: W]); else n_pass++;
    n_tot++; if (ovf_o !== 1'b0) $display("FAIL const_ovf got=%b exp=0", ovf_o); else n_pass++;
    tick(3);
    n_tot++; if (done !== 1'b1 || tout !== e) $display("FAIL const_hold done=%b elem0=%h exp done=1 elem0=22", done, tout[W-1:0]); else n_pass++;
    ena = 1'b0;
    tick(1);
    n_tot++; if (done !== 1'b0) $display("FAIL const_idle_done got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_window();
    tin = window_pat(); ena = 1'b1;
    tick(145);
    n_tot++; if (done !== 1'b1 || done_r !== 1'b1) $display("FAIL win_done got=%b/%b exp=1/1", done, done_r); else n_pass++;
    n_tot++; if (tout !== ofill(8'h7F)) $display("FAIL win_map elem %0d got=%h exp=7f", first_diff(tout, ofill(8'h7F)), tout[first_diff(tout, ofill(8'h7F))*W +: W]); else n_pass++;
    n_tot++; if (tout_r !== ofill(8'h7F)) $display("FAIL win_map_relu elem %0d got=%h exp=7f", first_diff(tout_r, ofill(8'h7F)), tout_r[first_diff(tout_r, ofill(8'h7F))*W +: W]); else n_pass++;
    ena = 1'b0; tick(1);
    // All -1.0: plain pool keeps 0x80, ReLU clamps to 0x00.
    tin = fill(8'h80); ena = 1'b1;
    tick(145);
    n_tot++; if (tout !== ofill(8'h80)) $display("FAIL neg_map elem %0d got=%h exp=80", first_diff(tout, ofill(8'h80)), tout[first_diff(tout, ofill(8'h80))*W +: W]); else n_pass++;
    n_tot++; if (tout_r !== ofill(8'h00)) $display("FAIL neg_map_relu elem %0d got=%h exp=00", first_diff(tout_r, ofill(8'h00)), tout_r[first_diff(tout_r, ofill(8'h00))*W +: W]); else n_pass++;
    ena = 1'b0; tick(1);
  endtask

  // Ramp (r*24+c) mod 128: all values non-negative. (0,0): max(0,1,24,25)=0x19.
  // (1,0): max(48,49,72,73)=0x49. (11,11): 550..575 wrap to 38,39,62,63 -> 0x3F.
  task automatic test_ramp();
    logic [OW-1:0] e;
    tin = ramp(); ena = 1'b1;
    e = pool_ref(ramp(), 1'b0);
    tick(145);
    n_tot++; if (oel(tout, 0, 0) !== 8'h19) $display("FAIL ramp_00 got=%h exp=19", oel(tout, 0, 0)); else n_pass++;
    n_tot++; if (oel(tout, 1, 0) !== 8'h49) $display("FAIL ramp_10 got=%h exp=49", oel(tout, 1, 0)); else n_pass++;
    n_tot++; if (oel(tout, 11, 11) !== 8'h3F) $display("FAIL ramp_1111 got=%h exp=3f", oel(tout, 11, 11)); else n_pass++;
    n_tot++; if (tout !== e) $display("FAIL ramp_map elem %0d got=%h exp=%h", first_diff(tout, e), tout[first_diff(tout, e)*W +: W], e[first_diff(tout, e)*W +: W]); else n_pass++;
    ena = 1'b0; tick(1);
  endtask

  // Pause after element 50 (written on edge 52) for 10 edges; unwritten
  // elements keep the zeros left by the reset.
  task automatic test_pause();
    logic [OW-1:0] e, part;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tin = ramp();
    e = pool_ref(ramp(), 1'b0);
    part = e;
    for (int i = 51; i < OD*OD; i++) part[i*W +: W] = '0;
    ena = 1'b1;
    tick(52);
    ena = 1'b0;
    tick(10);
    n_tot++; if (done !== 1'b0) $display("FAIL pause_done got=%b exp=0", done); else n_pass++;
    n_tot++; if (tout !== part) $display("FAIL pause_map elem %0d got=%h exp=%h", first_diff(tout, part), tout[first_diff(tout, part)*W +: W], part[first_diff(tout, part)*W +: W]); else n_pass++;
    ena = 1'b1;
    tick(92);
    n_tot++; if (done !== 1'b0) $display("FAIL pause_early_done got=%b exp=0", done); else n_pass++;
    tick(1);
    n_tot++; if (done !== 1'b1) $display("FAIL pause_done_155 got=%b exp=1", done); else n_pass++;
    n_tot++; if (tout !== e) $display("FAIL pause_final elem %0d got=%h exp=%h", first_diff(tout, e), tout[first_diff(tout, e)*W +: W], e[first_diff(tout, e)*W +: W]); else n_pass++;
    ena = 1'b0; tick(1);
  endtask

  task automatic test_reset_mid();
    tin = window_pat(); ena = 1'b1;
    tick(70);
    #2 rst_n = 1'b0;
    #1;
    n_tot++; if (tout !== '0) $display("FAIL rstmid_map elem %0d got=%h exp=00", first_diff(tout, '0), tout[first_diff(tout, '0)*W +: W]); else n_pass++;
    n_tot++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else n_pass++;
    tick(1);
    rst_n = 1'b1;
    tick(144);
    n_tot++; if (done !== 1'b0) $display("FAIL rerun_early_done got=%b exp=0", done); else n_pass++;
    tick(1);
    n_tot++; if (done !== 1'b1 || tout !== ofill(8'h7F)) $display("FAIL rerun_result done=%b elem0=%h exp done=1 elem0=7f", done, tout[W-1:0]); else n_pass++;
    ena = 1'b0; tick(1);
  endtask

  task automatic test_overflow();
    tin = fill(8'h22); ena = 1'b1;
    tick(30);
    n_tot++; if (ovf_o !== 1'b0) $display("FAIL ovf_pre got=%b exp=0", ovf_o); else n_pass++;
    ovf = 1'b1;
    tick(1);
    ovf = 1'b0;
    n_tot++; if (ovf_o !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf_o); else n_pass++;
    tick(114);
    n_tot++; if (done !== 1'b1 || ovf_o !== 1'b1) $display("FAIL ovf_at_done done=%b ovf=%b exp=1/1", done, ovf_o); else n_pass++;
    tick(3);
    n_tot++; if (ovf_o !== 1'b1 || ovf_r !== 1'b1) $display("FAIL ovf_sticky got=%b/%b exp=1/1", ovf_o, ovf_r); else n_pass++;
    ena = 1'b0;
    tick(1);
    n_tot++; if (done !== 1'b0) $display("FAIL ovf_idle_done got=%b exp=0", done); else n_pass++;
    ena = 1'b1;
    tick(1);
    n_tot++; if (ovf_o !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf_o); else n_pass++;
    ena = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_const();
    test_window();
    test_ramp();
    test_pause();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim time exceeded, passed=%0d total=%0d", n_pass, n_tot);
    $fatal(1, "timeout");
  end

endmodule
